// File: rtl/replay_reader_pkg.sv
// Shared defaults and FSM state encoding for the replay buffer read side.
package replay_reader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    SEND   = 2'd0,
    REWIND = 2'd1,
    REPLAY = 2'd2
  } state_t;

endpackage

// File: rtl/replay_mem.sv
// Replay buffer storage: one synchronous write port and a show-ahead asynchronous read port.
module replay_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= wdata;
  end

  assign rdata = mem[r_addr];

endmodule

// File: rtl/replay_reader.sv
// Read-side replay controller: streams retained entries with valid/ready, frees them on cumulative ack,
// and rewinds to the oldest unacked entry on nak (one dead REWIND cycle, then replay from head).
module replay_reader
  import replay_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W:0]   tx_seq,
  input  logic              ack,
  input  logic [ADDR_W:0]   ack_seq,
  input  logic              nak,
  output logic              replaying,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_W);

  logic [PW-1:0] head, tx_ptr, wr_ptr, replay_end;
  logic [PW-1:0] head_nxt, tx_inc, ack_dist, sent_dist, adv_dist, end_dist;
  logic          do_wr, hs, ack_ok, nak_ok, passed_end;
  state_t        state;

  assign count     = wr_ptr - head;
  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign tx_valid  = (tx_ptr != wr_ptr) && (state != REWIND);
  assign tx_seq    = tx_ptr;
  assign replaying = (state != SEND);
  assign w_addr    = wr_ptr[ADDR_W-1:0];
  assign r_addr    = tx_ptr[ADDR_W-1:0];

  assign do_wr  = wr && !full;
  assign hs     = tx_valid && tx_ready;
  assign tx_inc = tx_ptr + 1'b1;

  // All window tests are distances from head so they stay correct across pointer wrap.
  assign ack_dist  = ack_seq - head;
  assign sent_dist = tx_ptr - head;
  assign ack_ok    = ack && (ack_dist < sent_dist);
  assign head_nxt  = ack_ok ? ack_seq + 1'b1 : head;
  assign nak_ok    = nak && (tx_ptr != head_nxt);
  assign adv_dist  = head_nxt - head;
  assign end_dist  = replay_end - head;
  assign passed_end = ack_ok && (adv_dist >= end_dist);

  replay_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .we     (do_wr),
    .w_addr (w_addr),
    .wdata  (wdata),
    .r_addr (r_addr),
    .rdata  (tx_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tx_ptr     <= '0;
      wr_ptr     <= '0;
      replay_end <= '0;
      state      <= SEND;
    end else begin
      head <= head_nxt;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      // A same-cycle handshake is dropped: the rewind target wins over the increment.
      if (nak_ok) begin
        tx_ptr     <= head_nxt;
        replay_end <= tx_ptr;
        state      <= REWIND;
      end else begin
        if (hs) tx_ptr <= tx_inc;
        case (state)
          SEND:    state <= SEND;
          REWIND:  state <= REPLAY;
          REPLAY:  if ((hs && tx_inc == replay_end) || passed_end) state <= SEND;
          default: state <= SEND;
        endcase
      end
    end
  end

endmodule

// File: doc/replay_reader.md
# replay_reader

Read-side controller for the 8-entry replay buffer. It accepts entries from the producer, transmits them downstream with a valid/ready handshake, and retains each sent entry until the far end acknowledges it. On a negative acknowledge it rewinds and retransmits every unacknowledged entry. It pairs with the existing write-side fifo pointer logic and uses the same depth and pointer conventions.

## Interface
- DATA_W, default 8: entry width in bits.
- ADDR_W, default 3: address width; depth is 2**ADDR_W, so 8 entries by default.

Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- wr, in, 1: write request from the producer.
- wdata, in, DATA_W: entry to store.
- full, out, 1: retained count equals depth.
- empty, out, 1: no retained entries.
- count, out, ADDR_W+1: number of retained entries (sent-unacked plus unsent).
- tx_valid, out, 1: an entry is offered downstream.
- tx_ready, in, 1: downstream accepts the offered entry.
- tx_data, out, DATA_W: offered entry.
- tx_seq, out, ADDR_W+1: sequence number of the offered entry (the tx pointer, including its wrap bit).
- ack, in, 1: cumulative acknowledge.
- ack_seq, in, ADDR_W+1: last sequence number being acknowledged.
- nak, in, 1: negative acknowledge; retransmit everything unacknowledged.
- replaying, out, 1: high while in REWIND or REPLAY.
- w_addr, out, ADDR_W: write address (low bits of wr_ptr).
- r_addr, out, ADDR_W: transmit address (low bits of tx_ptr).

## Operation
- Three pointers, each ADDR_W+1 bits and wrapping modulo 2**(ADDR_W+1):
  - head: oldest unacknowledged entry.
  - tx_ptr: next entry to send.
  - wr_ptr: next free slot.
- Invariant: head ≤ tx_ptr ≤ wr_ptr in modular order.
- Status: count = wr_ptr − head; full = (count == depth); empty = (count == 0).
- Write: when wr && !full, mem[w_addr] ← wdata and wr_ptr increments. A write while full is dropped and no state changes.
- Transmit: tx_valid = (tx_ptr != wr_ptr) && state != REWIND. tx_data = mem[r_addr] (show-ahead). tx_seq = tx_ptr. On tx_valid && tx_ready, tx_ptr increments.
- Ack:
  - Valid only when (ack_seq − head) < (tx_ptr − head), i.e. it names a sent, unacknowledged entry. Then head ← ack_seq + 1.
  - An invalid ack is ignored.
- Nak:
  - If tx_ptr == head (nothing outstanding), nak is ignored.
  - Otherwise: save replay_end ← tx_ptr, set tx_ptr ← head (after any same-cycle ack), and go to REWIND.
- State machine:
  - SEND: normal operation.
  - SEND→REWIND on an accepted nak.
  - REWIND: lasts exactly one cycle with tx_valid forced 0; then goes to REPLAY.
  - REPLAY: transmits from the head.
  - REPLAY→SEND on the handshake that makes tx_ptr equal replay_end, or immediately if an ack moves head past replay_end.
  - A nak in REPLAY is handled as a new nak: go to REWIND with a new replay_end = current tx_ptr.
- Simultaneous events:
  - ack and nak in the same cycle: apply the ack first, then rewind to the new head.
  - Write, transmit and ack are all permitted in the same cycle.
  - A tx handshake in the same cycle as a nak is discarded by the rewind.
- Writes continue during REWIND and REPLAY. Entries written past replay_end are sent in SEND after the replay.

## Timing
- Reset values: all pointers 0; state SEND; full=0, empty=1, count=0, tx_valid=0, tx_seq=0, replaying=0, w_addr=0, r_addr=0. tx_data is undefined.
- Reset asserted mid-operation discards all retained entries asynchronously.
- Write at edge N: tx_valid rises after edge N (one-cycle latency), provided nothing else is pending.
- Ack at edge N: head, count and full update after edge N, so a stalled producer may write at edge N+1.
- Nak at edge N: tx_valid=0 and replaying=1 during cycle N+1. The first replayed entry (tx_seq = head) is offered in cycle N+2.
- Throughput: one entry per cycle when tx_ready is held high.

## Structure
- Shared package holds the DATA_W/ADDR_W defaults and the state encoding (SEND, REWIND, REPLAY).
- One natural sub-module: replay_mem, a 2**ADDR_W × DATA_W register array with one synchronous write port and an asynchronous read port.
- Pointer and FSM logic stays in replay_reader.

## Test plan
- Fill: reset, then 8 writes (data 0x10..0x17) with tx_ready=0 → full=1 after the 8th; a 9th write is dropped; count=8, empty=0.
- Stream: tx_ready=1, 4 writes → tx_seq 0..3 carry 0x10..0x13 on consecutive cycles; ack ack_seq=3 → count=0, empty=1.
- Replay: send seq 0..4, ack ack_seq=1, then nak → one cycle with tx_valid=0, then tx_seq 2,3,4 re-sent with the original data, then SEND with replaying=0.
- Simultaneous ack+nak: outstanding seq 0..5, ack_seq=2 and nak in the same cycle → replay starts at seq 3; count drops by 3.
- Wrap: run 20 entries through with periodic acks → tx_seq wraps 15→0, data stays intact, full/empty stay correct across the wrap; an invalid ack (ack_seq ≥ tx_ptr) is ignored.
- Async reset: assert reset during REPLAY → all outputs return to reset values immediately, without waiting for a clock edge.
